// File: rtl/mem_arb_pkg.sv
// Shared widths, FSM state type and port identifiers for the memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W = 18;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Grant selection between the fetch and data ports.
// MEM_ARB_ROUND_ROBIN_EN: alternate on contention; otherwise the data port has fixed priority.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic if_req,
    input  logic d_req,
    input  logic last_grant,
    output logic grant
);

    always_comb begin
        grant = PORT_IF;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (if_req && d_req) begin
            grant = (last_grant == PORT_IF) ? PORT_D : PORT_IF;
        end else if (d_req) begin
            grant = PORT_D;
        end
`else
        if (d_req) begin
            grant = PORT_D;
        end
`endif
    end

`ifndef MEM_ARB_ROUND_ROBIN_EN
    logic unused_pick;
    assign unused_pick = if_req ^ last_grant;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single multi-cycle memory block.
// Build option MEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration (see mem_arb_pick).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_byte,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              d_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              mem_memRead,
    output logic              mem_memWrite,
    output logic              mem_byteOperations,
    output logic              busy
);

    localparam logic [3:0] WAIT_EFF = (WAIT_CYCLES >= 1 && WAIT_CYCLES <= 15) ? 4'(WAIT_CYCLES) : 4'd1;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              port_q, port_d;
    logic              last_q, last_d;
    logic              we_q, we_d;
    logic              byte_q, byte_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              grant;

    mem_arb_pick u_pick (
        .if_req     (if_req),
        .d_req      (d_req),
        .last_grant (last_q),
        .grant      (grant)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        port_d     = port_q;
        last_d     = last_q;
        we_d       = we_q;
        byte_d     = byte_q;
        err_d      = err_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    port_d = grant;
                    last_d = grant;
                    cnt_d  = WAIT_EFF;
                    err_d  = 1'b0;
                    if (grant == PORT_D) begin
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                        we_d    = d_we;
                        byte_d  = d_byte;
                        // Misaligned word access never reaches memory; it is answered with an error.
                        if (!d_byte && d_addr[1:0] != 2'b00) begin
                            err_d   = 1'b1;
                            state_d = DONE;
                        end else begin
                            state_d = ACCESS;
                        end
                    end else begin
                        addr_d  = {if_addr[ADDR_W-1:2], 2'b00};
                        wdata_d = '0;
                        we_d    = 1'b0;
                        byte_d  = 1'b0;
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = DONE;
                    if (!we_q) begin
                        if (port_q == PORT_D) d_rdata_d  = mem_read_data;
                        else                  if_rdata_d = mem_read_data;
                    end
                end
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            port_q     <= PORT_IF;
            last_q     <= PORT_IF;
            we_q       <= 1'b0;
            byte_q     <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            port_q     <= port_d;
            last_q     <= last_d;
            we_q       <= we_d;
            byte_q     <= byte_d;
            err_q      <= err_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    logic in_access;
    logic in_done;
    assign in_access = (state_q == ACCESS);
    assign in_done   = (state_q == DONE);

    assign busy               = (state_q != IDLE);
    assign mem_address        = in_access ? addr_q  : '0;
    assign mem_write_data     = in_access ? wdata_q : '0;
    assign mem_byteOperations = in_access && byte_q;
    assign mem_memRead        = in_access && !we_q;
    assign mem_memWrite       = in_access && we_q;
    assign if_ack             = in_done && (port_q == PORT_IF);
    assign d_ack              = in_done && (port_q == PORT_D);
    assign d_err              = in_done && (port_q == PORT_D) && err_q;
    assign if_rdata           = if_rdata_q;
    assign d_rdata            = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int W     = 3;
    localparam int ITERS = 2000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        if_req, d_req, d_we, d_byte;
    logic [17:0] if_addr, d_addr, mem_address;
    logic [31:0] d_wdata, mem_read_data, if_rdata, d_rdata, mem_write_data;
    logic        if_ack, d_ack, d_err, mem_memRead, mem_memWrite, mem_byteOperations, busy;

    mem_port_arbiter #(.WAIT_CYCLES(W)) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_byte(d_byte), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
        .mem_address(mem_address), .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
        .mem_memRead(mem_memRead), .mem_memWrite(mem_memWrite),
        .mem_byteOperations(mem_byteOperations), .busy(busy)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: one outstanding transaction, described by its fields and cycles since grant.
    bit          m_active, m_port, m_we, m_byt, m_err, m_last;
    int          m_phase, m_end;
    logic [17:0] m_addr;
    logic [31:0] m_wdata, m_ird, m_drd;
    bit          if_pend, d_pend;
    bit          rst_done;

    function automatic bit pick_port(bit ir, bit dr, bit last);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (ir && dr) return !last;
`endif
        return dr;
    endfunction

    task automatic model_reset();
        m_active = 0; m_port = 0; m_last = 0; m_phase = 0; m_end = 0;
        m_ird = '0; m_drd = '0;
        if_pend = 0; d_pend = 0;
        if_req = 0; d_req = 0;
    endtask

    task automatic model_edge();
        if (m_active) begin
            m_phase++;
            if (!m_err && !m_we && m_phase == W + 1) begin
                if (m_port) m_drd = mem_read_data;
                else        m_ird = mem_read_data;
            end
            if (m_phase > m_end) m_active = 0;
        end else if (if_req || d_req) begin
            m_port = pick_port(if_req, d_req, m_last);
            m_last = m_port;
            if (m_port) begin
                m_we = d_we; m_byt = d_byte; m_addr = d_addr; m_wdata = d_wdata;
                m_err = !d_byte && (d_addr % 4 != 0);
            end else begin
                m_we = 0; m_byt = 0; m_addr = if_addr - (if_addr % 4); m_wdata = '0; m_err = 0;
            end
            m_active = 1;
            m_phase  = 1;
            m_end    = m_err ? 1 : W + 1;
        end
    endtask

    task automatic check_outputs();
        bit acc, done;
        acc  = m_active && !m_err && m_phase <= W;
        done = m_active && m_phase == m_end;
        check_eq("busy",     64'(busy),               64'(m_active));
        check_eq("memRead",  64'(mem_memRead),        64'(acc && !m_we));
        check_eq("memWrite", 64'(mem_memWrite),       64'(acc && m_we));
        check_eq("mem_addr", 64'(mem_address),        acc ? 64'(m_addr) : 64'd0);
        check_eq("mem_byte", 64'(mem_byteOperations), 64'(acc && m_byt));
        if (!acc || m_we)
            check_eq("mem_wdata", 64'(mem_write_data), acc ? 64'(m_wdata) : 64'd0);
        check_eq("if_ack",   64'(if_ack),   64'(done && !m_port));
        check_eq("d_ack",    64'(d_ack),    64'(done && m_port));
        check_eq("d_err",    64'(d_err),    64'(done && m_port && m_err));
        check_eq("if_rdata", 64'(if_rdata), 64'(m_ird));
        check_eq("d_rdata",  64'(d_rdata),  64'(m_drd));
    endtask

    task automatic drive_requesters();
        bit done;
        done = m_active && m_phase == m_end;
        if (done && !m_port) if_pend = 0;
        if (done &&  m_port) d_pend  = 0;
        if (!if_pend) begin
            if_req = 0;
            if ($urandom_range(1, 0) == 1) begin
                if_pend = 1; if_req = 1; if_addr = 18'($urandom);
            end
        end else if (m_active && !m_port && $urandom_range(3, 0) == 0) begin
            if_req = 0;
        end
        if (!d_pend) begin
            d_req = 0;
            if ($urandom_range(1, 0) == 1) begin
                d_pend = 1; d_req = 1;
                d_we = 1'($urandom); d_byte = 1'($urandom);
                d_addr = 18'($urandom); d_wdata = $urandom;
                if ($urandom_range(1, 0) == 1) d_addr[1:0] = 2'b00;
            end
        end else if (m_active && m_port && $urandom_range(3, 0) == 0) begin
            d_req = 0;
        end
        mem_read_data = $urandom;
    endtask

    initial begin
        reset_n = 0;
        if_addr = '0; d_we = 0; d_byte = 0; d_addr = '0; d_wdata = '0; mem_read_data = '0;
        rst_done = 0;
        model_reset();
        #1;
        check_outputs();
        #11 reset_n = 1;
        for (int it = 0; it < ITERS; it++) begin
            @(posedge clk);
            model_edge();
            #1;
            check_outputs();
            drive_requesters();
            // Reset pulse in the middle of a memory access: everything drops, no ack follows.
            if (!rst_done && it > 600 && m_active && !m_err && m_phase == 2) begin
                rst_done = 1;
                #2 reset_n = 0;
                model_reset();
                #1 check_outputs();
                #2 reset_n = 1;
            end
        end
        check_eq("reset_exercised", 64'(rst_done), 64'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
